ahb_cfg_initiator: RTL and testbench
====================================

# ahb_cfg_initiator

AHB-Lite manager that turns simple one-shot register requests into single AHB-Lite transfers. It is the initiator that programs and reads back AHB register responders such as the clock/reset controller's divider-scale register. It supports an optional write-then-readback verify sequence and reports bus error, readback mismatch and wait-state count with each response. It sits between boot/configuration logic and the AHB interconnect, with one transfer outstanding at a time.

## Interface
- `HPROT_VAL`, default 4'b0011, constant driven on HPROT (non-cacheable, privileged data).
- `WAIT_W`, default 8, width of the saturating wait-state counter.
- `HCLK`  in  1  system clock; all logic on its rising edge.
- `HRESET`  in  1  **one clock; reset is synchronous and active-high**.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on `req_valid && req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_verify`  in  1  write only: read back the same address after the write and compare.
- `req_addr`  in  32  byte address.
- `req_size`  in  3  HSIZE code (0 byte, 1 half, 2 word).
- `req_wdata`  in  32  write data, already on the correct byte lanes (no steering).
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  read or readback data.
- `rsp_err`  out  1  an HRESP error ended the sequence.
- `rsp_mismatch`  out  1  verify compare failed.
- `rsp_wait_cnt`  out  WAIT_W  total HREADY-low cycles in the sequence, saturating.
- `HADDR` out 32; `HTRANS` out 2; `HWRITE` out 1; `HSIZE` out 3; `HBURST` out 3 (always SINGLE 3'b000); `HPROT` out 4; `HWDATA` out 32.
- `HRDATA` in 32; `HREADY` in 1; `HRESP` in 1 (1 = ERROR).

## Operation
- FSM states:
  - IDLE: `req_ready` = 1; on accept, capture the request fields and go to ADDR.
  - ADDR: drive HTRANS = NONSEQ (2'b10), with HADDR, HWRITE and HSIZE taken from the captured request. Stay while HREADY = 0. When HREADY = 1, go to DATA.
  - DATA: drive HTRANS = IDLE. HWDATA = captured wdata when writing, otherwise 0. Stay while HREADY = 0, incrementing the wait counter. When HREADY = 1:
    - HRESP = 1: go to RESP with err = 1.
    - Read: capture HRDATA, go to RESP.
    - Write with verify: go to RB_ADDR.
    - Write without verify: go to RESP.
  - RB_ADDR: HTRANS = NONSEQ, HWRITE = 0, same address and size. Go to RB_DATA on HREADY.
  - RB_DATA: HTRANS = IDLE. Wait for HREADY. On completion:
    - Capture HRDATA.
    - If HRESP = 1, set err.
    - Otherwise set mismatch when the masked readback differs from the masked wdata. Mask by size: size 0 compares [7:0], size 1 compares [15:0], any other size compares [31:0].
    - Go to RESP.
  - RESP: `rsp_valid` = 1 for one cycle, then IDLE.
- Transfers are single only; no overlap of a new address phase with the current data phase.
- A write error never triggers readback; `rsp_mismatch` = 0 whenever `rsp_err` = 1.
- `rsp_rdata` = 0 for writes without verify and on error.
- The wait counter clears on accept and saturates at 2^WAIT_W-1. It also counts HREADY-low cycles in ADDR and RB_ADDR.
- Response fields hold their values until the next accept.

## Timing
- Reset (while HRESET = 1 at an edge):
  - state = IDLE.
  - HTRANS = 2'b00; HADDR, HWDATA, HWRITE and HSIZE = 0.
  - `rsp_valid`, `rsp_err`, `rsp_mismatch`, `rsp_rdata` and `rsp_wait_cnt` = 0.
  - `req_ready` is forced 0 while HRESET = 1.
- Reset mid-transfer: next cycle is IDLE with HTRANS IDLE; no response is issued and the in-flight request is dropped.
- Zero-wait-state latency:
  - Accept at edge 0.
  - Address phase in cycle 1.
  - Data phase in cycle 2.
  - `rsp_valid` in cycle 3.
  - `req_ready` in cycle 4.
  - Minimum period is 4 cycles per plain transfer and 6 per verified write.
- Two-cycle AHB error (HREADY = 0 with HRESP = 1, then HREADY = 1 with HRESP = 1):
  - The first cycle counts as a wait state.
  - The error is captured on the second cycle.
- `req_valid` held during non-IDLE states is ignored, not queued.

## Structure
- Shared package `ahb_pkg` holds:
  - HTRANS_IDLE/NONSEQ.
  - HSIZE_BYTE/HALF/WORD.
  - HBURST_SINGLE.
  - The FSM state enum (IDLE, ADDR, DATA, RB_ADDR, RB_DATA, RESP).
  - The size-to-compare-mask function.
- Single flat module; no sub-module. The wait counter and size mask are inline.

## Test plan
- Word write 0x00040302 to 0x0, no verify, HREADY tied 1:
  - NONSEQ in cycle 1, HWDATA = 0x00040302 in cycle 2.
  - `rsp_valid` in cycle 3 with err = 0, wait_cnt = 0.
- Verified byte write of 0x05, with the responder returning zero-extended 0x00000005 on readback:
  - Readback transfer has HWRITE = 0.
  - Response: mismatch = 0, rdata = 0x00000005.
- Verified word write of 0x00020202, with the responder returning 0x00020203:
  - Response: mismatch = 1, err = 0, rdata = 0x00020203.
- Read with HREADY low for 3 cycles in the data phase, then HRDATA = 0xDEADBEEF:
  - Response: rdata = 0xDEADBEEF, wait_cnt = 3.
- Verified write hit by a two-cycle error:
  - No readback transfer is issued.
  - Response: err = 1, mismatch = 0, wait_cnt = 1.
- HRESET asserted during DATA:
  - Next cycle HTRANS = 0, no `rsp_valid`.
  - `req_ready` = 1 in the first cycle after reset deasserts.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, initiator FSM states and the size-to-compare-mask helper.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DATA    = 3'd2,
        ST_RB_ADDR = 3'd3,
        ST_RB_DATA = 3'd4,
        ST_RESP    = 3'd5
    } cfg_state_t;

    // Bits that take part in the write/readback compare; sizes above a word compare everything.
    function automatic logic [31:0] size_mask(input logic [2:0] size);
        logic [31:0] mask;
        case (size)
            HSIZE_BYTE: mask = 32'h0000_00FF;
            HSIZE_HALF: mask = 32'h0000_FFFF;
            HSIZE_WORD: mask = 32'hFFFF_FFFF;
            default:    mask = 32'hFFFF_FFFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb_cfg_initiator.sv
// AHB-Lite manager turning one-shot register requests into single transfers,
// with optional write-then-readback verify and a saturating wait-state count.
module ahb_cfg_initiator
    import ahb_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011,
    parameter int         WAIT_W    = 8
) (
    input  logic              HCLK,
    input  logic              HRESET,
    // request side
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_verify,
    input  logic [31:0]       req_addr,
    input  logic [2:0]        req_size,
    input  logic [31:0]       req_wdata,
    // response side
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_mismatch,
    output logic [WAIT_W-1:0] rsp_wait_cnt,
    // AHB-Lite manager port
    output logic [31:0]       HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic [31:0]       HWDATA,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    cfg_state_t        r_state;
    logic              r_write;
    logic              r_verify;
    logic [2:0]        r_size;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic              r_mismatch;
    logic              r_rsp_valid;
    logic [WAIT_W-1:0] r_wait;
    logic [1:0]        r_htrans;
    logic [31:0]       r_haddr;
    logic              r_hwrite;
    logic [2:0]        r_hsize;
    logic [31:0]       r_hwdata;

    logic              w_accept;
    logic              w_bus_busy;
    logic              w_wait_inc;
    logic              w_rb_differs;

    // Ready only in IDLE, and never while reset is held.
    assign req_ready  = (r_state == ST_IDLE) && !HRESET;
    assign w_accept   = req_valid && req_ready;

    // Every state that owns an address or data phase counts stalled cycles.
    assign w_bus_busy = (r_state == ST_ADDR)    || (r_state == ST_DATA) ||
                        (r_state == ST_RB_ADDR) || (r_state == ST_RB_DATA);
    assign w_wait_inc = w_bus_busy && !HREADY && (r_wait != {WAIT_W{1'b1}});

    assign w_rb_differs = ((HRDATA ^ r_wdata) & size_mask(r_size)) != 32'd0;

    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rdata;
    assign rsp_err      = r_err;
    assign rsp_mismatch = r_mismatch;
    assign rsp_wait_cnt = r_wait;

    assign HADDR  = r_haddr;
    assign HTRANS = r_htrans;
    assign HWRITE = r_hwrite;
    assign HSIZE  = r_hsize;
    assign HBURST = HBURST_SINGLE;
    assign HPROT  = HPROT_VAL;
    assign HWDATA = r_hwdata;

    // Saturating wait-state counter, cleared when a new request is taken.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_wait <= '0;
        end else if (w_accept) begin
            r_wait <= '0;
        end else if (w_wait_inc) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    // Sequence FSM with registered bus and response outputs.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_verify    <= 1'b0;
            r_size      <= 3'd0;
            r_wdata     <= 32'd0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
            r_mismatch  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_htrans    <= HTRANS_IDLE;
            r_haddr     <= 32'd0;
            r_hwrite    <= 1'b0;
            r_hsize     <= 3'd0;
            r_hwdata    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write    <= req_write;
                        r_verify   <= req_write && req_verify;
                        r_size     <= req_size;
                        r_wdata    <= req_wdata;
                        r_rdata    <= 32'd0;
                        r_err      <= 1'b0;
                        r_mismatch <= 1'b0;
                        r_htrans   <= HTRANS_NONSEQ;
                        r_haddr    <= req_addr;
                        r_hwrite   <= req_write;
                        r_hsize    <= req_size;
                        r_state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        r_htrans <= HTRANS_IDLE;
                        r_hwdata <= r_write ? r_wdata : 32'd0;
                        r_state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (HREADY) begin
                        r_hwdata <= 32'd0;
                        if (HRESP) begin
                            // An errored write never goes on to readback.
                            r_err       <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else if (!r_write) begin
                            r_rdata     <= HRDATA;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else if (r_verify) begin
                            r_htrans <= HTRANS_NONSEQ;
                            r_hwrite <= 1'b0;
                            r_state  <= ST_RB_ADDR;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_RB_ADDR: begin
                    if (HREADY) begin
                        r_htrans <= HTRANS_IDLE;
                        r_state  <= ST_RB_DATA;
                    end
                end
                ST_RB_DATA: begin
                    if (HREADY) begin
                        // On error the readback data is discarded so rdata stays 0.
                        if (HRESP) begin
                            r_err <= 1'b1;
                        end else begin
                            r_rdata    <= HRDATA;
                            r_mismatch <= w_rb_differs;
                        end
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_htrans    <= HTRANS_IDLE;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_cfg_initiator.sv
// Scoreboard bench: a behavioural responder with a register map, a request-level
// reference model feeding an expected-response queue, and a response monitor.
module tb_ahb_cfg_initiator;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        req_valid, req_ready, req_write, req_verify;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid, rsp_err, rsp_mismatch;
    logic [31:0] rsp_rdata;
    logic [7:0]  rsp_wait_cnt;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    always #5 HCLK = ~HCLK;

    ahb_cfg_initiator #(.HPROT_VAL(4'b0011), .WAIT_W(8)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_verify(req_verify), .req_addr(req_addr), .req_size(req_size),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_mismatch(rsp_mismatch), .rsp_wait_cnt(rsp_wait_cnt),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          mm;
        int          wt;
        int          nph;
    } exp_t;
    exp_t exp_q[$];

    // Per-request responder plan: index 0 = main transfer, 1 = readback.
    int          pa[2];
    int          pd[2];
    bit          pe[2];
    logic [31:0] pcor;
    logic [31:0] cur_addr, cur_wdata;
    logic [2:0]  cur_size;
    logic        cur_write;

    logic [31:0] mmem[logic [31:0]];
    logic [31:0] rmem[logic [31:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [2:0] sz);
        if (sz == 3'd0) return 32'h0000_00FF;
        if (sz == 3'd1) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] mval(input logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] rval(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : dflt(a);
    endfunction

    // Reference model: what the whole request should report, from the plan.
    task automatic model_push(input bit wr, input bit vf, input logic [31:0] a,
                              input logic [2:0] sz, input logic [31:0] wd);
        exp_t e;
        logic [31:0] m, rb;
        int w;
        m = lane_mask(sz);
        w = pa[0] + pd[0];
        e.err = pe[0]; e.mm = 1'b0; e.rdata = 32'd0; e.nph = 1;
        if (!wr) begin
            if (!pe[0]) e.rdata = mval(a);
        end else begin
            if (!pe[0]) mmem[a] = wd & m;
            if (vf && !pe[0]) begin
                e.nph = 2;
                w += pa[1] + pd[1];
                if (pe[1]) e.err = 1'b1;
                else begin
                    rb = mval(a) ^ pcor;
                    e.rdata = rb;
                    e.mm = ((rb ^ wd) & m) != 32'd0;
                end
            end
        end
        e.wt = (w > 255) ? 255 : w;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input bit wr, input bit vf, input logic [31:0] a,
                           input logic [2:0] sz, input logic [31:0] wd,
                           input int a0, input int d0, input bit e0,
                           input int a1, input int d1, input bit e1,
                           input logic [31:0] cor);
        pa[0] = a0; pd[0] = d0; pe[0] = e0;
        pa[1] = a1; pd[1] = d1; pe[1] = e1;
        pcor = cor;
        cur_addr = a; cur_size = sz; cur_write = wr; cur_wdata = wd;
        req_write = wr; req_verify = vf; req_addr = a; req_size = sz; req_wdata = wd;
    endtask

    // Full request: handshake, optional req_valid hold, bounded wait for the response.
    task automatic run(input bit wr, input bit vf, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd,
                       input int a0, input int d0, input bit e0,
                       input int a1, input int d1, input bit e1,
                       input logic [31:0] cor, input bit hold);
        bit got;
        set_req(wr, vf, a, sz, wd, a0, d0, e0, a1, d1, e1, cor);
        model_push(wr, vf, a, sz, wd);
        @(posedge HCLK); #1;
        req_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge HCLK);
            if (req_ready) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
        @(posedge HCLK); #1;
        if (!hold) req_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 2000 && !got; k++) begin
            @(negedge HCLK);
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                req_valid = 1'b0;
            end else if (hold) begin
                req_addr = $urandom; req_wdata = $urandom; req_write = $urandom_range(0, 1);
            end
        end
        req_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL rsp_timeout actual=0 required=1");
        end
    endtask

    // Reset dropped into a transfer after n cycles past the accept edge.
    task automatic reset_mid(input int a0, input int d0, input int n);
        set_req(1'b0, 1'b0, 32'h0000_0008, 3'd2, 32'd0, a0, d0, 1'b0, 0, 0, 1'b0, 32'd0);
        @(posedge HCLK); #1;
        req_valid = 1'b1;
        @(posedge HCLK); #1;
        req_valid = 1'b0;
        repeat (n) @(posedge HCLK);
        #1 HRESET = 1'b1;
        @(negedge HCLK);
        @(negedge HCLK);
        chk("rst_mid_htrans", {30'd0, HTRANS}, 32'd0);
        chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("rst_after_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (4) @(negedge HCLK);
    endtask

    // Behavioural AHB responder with its own register map.
    int          r_idx = 0;
    int          n_addr = 0;
    bit          dp_active = 1'b0;
    bit          seq_new = 1'b1;
    int          dp_cnt = 0;
    int          ap_cnt = 0;
    logic [31:0] ph_addr;
    logic [2:0]  ph_size;
    logic        ph_write;

    initial begin
        int pi;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'd0;
        forever begin
            @(posedge HCLK); #1;
            pi = (r_idx > 1) ? 1 : r_idx;
            HRDATA = $urandom;
            if (HRESET) begin
                dp_active = 1'b0; seq_new = 1'b1; ap_cnt = 0; dp_cnt = 0;
                HREADY = 1'b1; HRESP = 1'b0;
            end else if (dp_active) begin
                if (dp_cnt < pd[pi]) begin
                    HREADY = 1'b0;
                    HRESP = pe[pi] && (dp_cnt == pd[pi] - 1);
                    dp_cnt++;
                end else begin
                    HREADY = 1'b1;
                    HRESP = pe[pi];
                    if (ph_write) begin
                        chk("data_hwdata", HWDATA, cur_wdata);
                        if (!pe[pi]) rmem[ph_addr] = HWDATA & lane_mask(ph_size);
                    end else if (!pe[pi]) begin
                        HRDATA = rval(ph_addr) ^ ((pi == 1) ? pcor : 32'd0);
                    end
                    dp_active = 1'b0;
                    r_idx++;
                end
            end else if (HTRANS == 2'b10) begin
                if (seq_new) begin
                    seq_new = 1'b0; r_idx = 0; n_addr = 0; pi = 0;
                end
                if (ap_cnt < pa[pi]) begin
                    HREADY = 1'b0; HRESP = 1'b0;
                    ap_cnt++;
                end else begin
                    HREADY = 1'b1; HRESP = 1'b0;
                    ap_cnt = 0;
                    ph_addr = HADDR; ph_size = HSIZE; ph_write = HWRITE;
                    chk(pi == 0 ? "addr_haddr" : "rb_haddr", HADDR, cur_addr);
                    chk(pi == 0 ? "addr_hsize" : "rb_hsize", {29'd0, HSIZE}, {29'd0, cur_size});
                    chk(pi == 0 ? "addr_hwrite" : "rb_hwrite", {31'd0, HWRITE},
                        (pi == 0) ? {31'd0, cur_write} : 32'd0);
                    chk("addr_hburst", {29'd0, HBURST}, 32'd0);
                    chk("addr_hprot", {28'd0, HPROT}, 32'd3);
                    n_addr++;
                    dp_active = 1'b1; dp_cnt = 0;
                end
            end else begin
                HREADY = 1'b1; HRESP = 1'b0;
            end
            if (rsp_valid === 1'b1) seq_new = 1'b1;
        end
    end

    // Response monitor: every rsp_valid pulse is matched against the queue head.
    int rsp_cnt = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (rsp_valid === 1'b1) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    chk("rsp_mismatch", {31'd0, rsp_mismatch}, {31'd0, e.mm});
                    chk("rsp_wait_cnt", 32'(rsp_wait_cnt), 32'(e.wt));
                    chk("rsp_addr_phases", 32'(n_addr), 32'(e.nph));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          wr, vf, e0, e1, hold;
        logic [31:0] a, wd, cor;
        logic [2:0]  sz;
        int          r, d0, d1;

        HRESET = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_verify = 1'b0;
        req_addr = 32'd0; req_size = 3'd0; req_wdata = 32'd0;
        pa[0] = 0; pa[1] = 0; pd[0] = 0; pd[1] = 0; pe[0] = 1'b0; pe[1] = 1'b0; pcor = 32'd0;
        cur_addr = 32'd0; cur_size = 3'd0; cur_write = 1'b0; cur_wdata = 32'd0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("reset_htrans", {30'd0, HTRANS}, 32'd0);
        chk("reset_haddr", HADDR, 32'd0);
        chk("reset_hwdata", HWDATA, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset_wait_cnt", 32'(rsp_wait_cnt), 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        // Zero-wait word write: cycle-exact latency.
        set_req(1'b1, 1'b0, 32'd0, 3'd2, 32'h0004_0302, 0, 0, 1'b0, 0, 0, 1'b0, 32'd0);
        model_push(1'b1, 1'b0, 32'd0, 3'd2, 32'h0004_0302);
        @(posedge HCLK); #1;
        req_valid = 1'b1;
        @(posedge HCLK); #1;
        req_valid = 1'b0;
        @(negedge HCLK);
        chk("lat_c1_htrans", {30'd0, HTRANS}, 32'd2);
        chk("lat_c1_hwrite", {31'd0, HWRITE}, 32'd1);
        @(negedge HCLK);
        chk("lat_c2_htrans", {30'd0, HTRANS}, 32'd0);
        chk("lat_c2_hwdata", HWDATA, 32'h0004_0302);
        @(negedge HCLK);
        chk("lat_c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge HCLK);
        chk("lat_c4_req_ready", {31'd0, req_ready}, 32'd1);
        chk("lat_c4_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Directed cases.
        run(1'b1, 1'b1, 32'h10, 3'd0, 32'h0000_0005, 0, 0, 1'b0, 0, 0, 1'b0, 32'd0, 1'b0);
        run(1'b1, 1'b1, 32'h14, 3'd2, 32'h0002_0202, 0, 0, 1'b0, 0, 0, 1'b0, 32'd1, 1'b0);
        mmem[32'h20] = 32'hDEAD_BEEF;
        rmem[32'h20] = 32'hDEAD_BEEF;
        run(1'b0, 1'b0, 32'h20, 3'd2, 32'd0, 0, 3, 1'b0, 0, 0, 1'b0, 32'd0, 1'b0);
        run(1'b1, 1'b1, 32'h30, 3'd2, 32'h1234_5678, 0, 1, 1'b1, 0, 0, 1'b0, 32'd0, 1'b0);
        run(1'b1, 1'b1, 32'h34, 3'd1, 32'hABCD_1234, 1, 0, 1'b0, 2, 1, 1'b1, 32'd0, 1'b1);
        run(1'b1, 1'b1, 32'h38, 3'd1, 32'h0000_1234, 0, 0, 1'b0, 0, 0, 1'b0, 32'h0001_0000, 1'b0);
        run(1'b0, 1'b0, 32'h3C, 3'd2, 32'd0, 150, 150, 1'b0, 0, 0, 1'b0, 32'd0, 1'b0);

        // Reset during ADDR (held by wait states) and during DATA.
        reset_mid(4, 0, 0);
        reset_mid(0, 5, 1);

        // Randomised traffic.
        for (int t = 0; t < 60; t++) begin
            wr = $urandom_range(0, 1);
            vf = $urandom_range(0, 1);
            a = 32'($urandom_range(0, 5)) << 2;
            r = $urandom_range(0, 9);
            sz = (r < 3) ? 3'(r) : ((r < 8) ? 3'd2 : 3'($urandom_range(3, 7)));
            wd = $urandom;
            e0 = ($urandom_range(0, 9) == 0);
            e1 = ($urandom_range(0, 9) == 0);
            d0 = $urandom_range(e0 ? 1 : 0, 3);
            d1 = $urandom_range(e1 ? 1 : 0, 3);
            cor = ($urandom_range(0, 4) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
            hold = $urandom_range(0, 1);
            run(wr, vf, a, sz, wd, $urandom_range(0, 2), d0, e0,
                $urandom_range(0, 2), d1, e1, cor, hold);
        end

        repeat (5) @(negedge HCLK);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
